score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; the ports are named clk and resetN.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  system clock.
- resetN  in  1  async active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- scoreUpdate  in  8  points to add; nonzero for exactly one cycle per kill.
- playerHit  in  1  alien shot overlaps player; level, may stay high many cycles per frame.
- startGame  in  1  level, high while start/new-game key is held in the start states.
- gameEnded  in  1  level, high during end-of-game screens.
- keyCoinN  in  1  coin key, active-low, already debounced.
- score  out  14  current score, binary, 0..9999.
- hiScore  out  14  best score since reset, binary.
- lives  out  3  remaining lives, 0..7.
- credits  out  4  stored credits, 0..9.
- gameLose  out  1  level, game lost.
- invuln  out  1  high while the player is in the dying/respawn window.

Function
REQ-003 The block SHALL implement the states IDLE, PLAY, DYING and OVER.
REQ-004 Coin: a falling edge of keyCoinN SHALL increment credits one cycle later, saturating at 9, in every state.
REQ-005 Start: a rising edge of startGame in IDLE or OVER with credits>0 SHALL, on the next clock:
- decrement credits;
- clear score;
- set lives=3;
- clear gameLose and the bonus flag;
- enter PLAY.
REQ-006 A startGame rising edge with credits=0 SHALL be ignored.
REQ-007 Coin and start on the same cycle SHALL leave credits unchanged (net +1-1).
REQ-008 In PLAY or DYING, a nonzero scoreUpdate SHALL be added to score on the next clock; if the sum exceeds 9999, score SHALL be set to 9999.
REQ-009 scoreUpdate SHALL be ignored in IDLE and OVER.
REQ-010 Bonus life: the first time score reaches or crosses 1500 in a game, lives SHALL increment (saturate 7); this SHALL happen at most once per game.
REQ-011 Hit acceptance: in PLAY, the first cycle of playerHit after the latest startOfFrame SHALL be accepted. Further playerHit cycles SHALL be ignored until the next startOfFrame.
REQ-012 An accepted hit SHALL decrement lives on the next clock.
REQ-013 If an accepted hit leaves lives>0, the block SHALL enter DYING with a 6-bit frame counter loaded with 60.
REQ-014 If an accepted hit leaves lives=0, the block SHALL enter OVER and set gameLose=1 on the same clock.
REQ-015 DYING SHALL ignore playerHit and hold invuln=1.
REQ-016 In DYING, the frame counter SHALL decrement on each startOfFrame; when it reaches 0, the block SHALL return to PLAY.
REQ-017 A hit and the bonus life on the same cycle SHALL both apply (net lives change 0); DYING SHALL still be entered.
REQ-018 A hit and scoreUpdate on the same cycle SHALL both apply.
REQ-019 On entering OVER, if score>hiScore, hiScore SHALL be updated to score on that same clock.
REQ-020 A rising edge of gameEnded while in PLAY or DYING SHALL force OVER with gameLose=1 and apply the REQ-019 hiScore update.
REQ-021 gameLose SHALL stay 1 throughout OVER until an accepted start (REQ-005).
REQ-022 A startGame edge accepted in OVER SHALL drop gameLose on the clock it enters PLAY.
REQ-023 All outputs SHALL be registered; input-to-output latency SHALL be 1 clock.
REQ-024 Edge detection SHALL use one registered copy each of keyCoinN, startGame and gameEnded, each cleared to its inactive value (keyCoinN=1, startGame=0, gameEnded=0) at reset.

Reset
REQ-025 While resetN=0, the block SHALL hold score=0, hiScore=0, lives=0, credits=0, gameLose=0, invuln=0, state=IDLE, frame counter=0 and bonus flag=0.
REQ-026 Reset asserted mid-game SHALL clear all state including hiScore and credits; operation SHALL resume from IDLE on the first clock after release.
REQ-027 A keyCoinN held low through reset release SHALL NOT count as a coin.

Verification
REQ-028 The bench SHALL cover these directed scenarios (stimulus -> required response):
- 3 coin presses, then startGame edge -> credits 3 then 2; lives=3; score=0; state PLAY.
- 12 coin presses -> credits=9 (saturated).
- startGame edge with credits=0 -> no state change.
- scoreUpdate pulses 100 ×15 -> score=1500 and lives 3→4 once.
- 10 further pulses of 100 -> no further lives.
- score=9990, scoreUpdate=30 -> score=9999.
- playerHit high 200 cycles within one frame -> lives drop by exactly 1; invuln=1 for 60 startOfFrame pulses; then PLAY.
- Hits during DYING -> ignored.
- lives=1, accepted hit -> lives=0; gameLose=1; OVER; hiScore=score if larger.
- Second game with lower score -> hiScore unchanged.
- startGame edge in OVER with credits>0 -> gameLose=0 one clock later.
- resetN pulsed low mid-PLAY -> all outputs 0, IDLE.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: score, high score, lives and credit bookkeeping for a
// shoot-'em-up style game, driven by a four-state game FSM.
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle pulse per video frame
//   scoreUpdate   points to add; nonzero for one cycle per kill
//   playerHit     level, alien shot overlaps the player
//   startGame     level, start / new-game key held
//   gameEnded     level, high during end-of-game screens
//   keyCoinN      coin key, active-low, debounced
//   score         current score, 0..9999
//   hiScore       best score since reset
//   lives         remaining lives, 0..7
//   credits       stored credits, 0..9
//   gameLose      level, game lost (held through the over state)
//   invuln        high while the player is dying / respawning
//
// All outputs are registered; every input affects the outputs one clock later.
module score_keeper (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [7:0]  scoreUpdate,
  input  logic        playerHit,
  input  logic        startGame,
  input  logic        gameEnded,
  input  logic        keyCoinN,
  output logic [13:0] score,
  output logic [13:0] hiScore,
  output logic [2:0]  lives,
  output logic [3:0]  credits,
  output logic        gameLose,
  output logic        invuln
);

  localparam logic [13:0] MaxScore    = 14'd9999;
  localparam logic [13:0] BonusScore  = 14'd1500;
  localparam logic [5:0]  DyingFrames = 6'd60;
  localparam logic [3:0]  MaxCredits  = 4'd9;
  localparam logic [2:0]  StartLives  = 3'd3;

  typedef enum logic [1:0] {StIdle, StPlay, StDying, StOver} state_e;

  state_e     state;
  logic [5:0] frameCnt;
  logic       bonusDone;
  logic       hitArmed;
  logic       coinPrev;
  logic       coinArmed;
  logic       startPrev;
  logic       endedPrev;

  logic        coinEdge;
  logic        startEdge;
  logic        endEdge;
  logic        active;
  logic        startOk;
  logic        hitOk;
  logic        bonusNow;
  logic        goOver;
  logic [14:0] scoreSum;
  logic [13:0] scoreNext;
  logic [3:0]  livesSum;
  logic [2:0]  livesNext;
  logic [4:0]  creditsSum;
  logic [3:0]  creditsNext;
  logic [13:0] hiNext;

  always_comb begin
    // coinArmed stays low until the key has been seen released after reset,
    // so a key held down through reset release never counts as a coin.
    coinEdge  = coinArmed & coinPrev & ~keyCoinN;
    startEdge = startGame & ~startPrev;
    endEdge   = gameEnded & ~endedPrev;
    active    = (state == StPlay) || (state == StDying);
    startOk   = startEdge && (credits != 4'd0) && (state == StIdle || state == StOver);
    // Only the first hit cycle after a frame pulse is taken.
    hitOk     = (state == StPlay) && playerHit && hitArmed;

    scoreSum  = {1'b0, score} + {7'd0, scoreUpdate};
    scoreNext = score;
    if (active && (scoreUpdate != 8'd0)) begin
      scoreNext = (scoreSum > {1'b0, MaxScore}) ? MaxScore : scoreSum[13:0];
    end
    bonusNow  = active && !bonusDone && (scoreNext >= BonusScore);

    // Bonus and hit on the same cycle cancel; the sum is clamped afterwards.
    livesSum  = {1'b0, lives} + {3'd0, bonusNow} - {3'd0, hitOk};
    livesNext = (livesSum > 4'd7) ? 3'd7 : livesSum[2:0];
    goOver    = active && (endEdge || (hitOk && (livesNext == 3'd0)));

    // Coin and accepted start on the same cycle net to zero.
    creditsSum  = {1'b0, credits} + {4'd0, coinEdge} - {4'd0, startOk};
    creditsNext = (creditsSum > {1'b0, MaxCredits}) ? MaxCredits : creditsSum[3:0];

    hiNext = (scoreNext > hiScore) ? scoreNext : hiScore;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= StIdle;
      score     <= 14'd0;
      hiScore   <= 14'd0;
      lives     <= 3'd0;
      credits   <= 4'd0;
      gameLose  <= 1'b0;
      invuln    <= 1'b0;
      frameCnt  <= 6'd0;
      bonusDone <= 1'b0;
      hitArmed  <= 1'b0;
      coinPrev  <= 1'b1;
      coinArmed <= 1'b0;
      startPrev <= 1'b0;
      endedPrev <= 1'b0;
    end else begin
      coinPrev  <= keyCoinN;
      coinArmed <= coinArmed | keyCoinN;
      startPrev <= startGame;
      endedPrev <= gameEnded;
      credits   <= creditsNext;

      if (startOfFrame) begin
        hitArmed <= 1'b1;
      end else if (hitOk) begin
        hitArmed <= 1'b0;
      end

      case (state)
        StIdle, StOver: begin
          if (startOk) begin
            state     <= StPlay;
            score     <= 14'd0;
            lives     <= StartLives;
            gameLose  <= 1'b0;
            bonusDone <= 1'b0;
            invuln    <= 1'b0;
            frameCnt  <= 6'd0;
          end
        end
        StPlay, StDying: begin
          score <= scoreNext;
          lives <= livesNext;
          if (bonusNow) begin
            bonusDone <= 1'b1;
          end
          if (goOver) begin
            state    <= StOver;
            gameLose <= 1'b1;
            invuln   <= 1'b0;
            frameCnt <= 6'd0;
            hiScore  <= hiNext;
          end else if (hitOk) begin
            state    <= StDying;
            invuln   <= 1'b1;
            frameCnt <= DyingFrames;
          end else if ((state == StDying) && startOfFrame) begin
            frameCnt <= frameCnt - 6'd1;
            if (frameCnt <= 6'd1) begin
              state  <= StPlay;
              invuln <= 1'b0;
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed game scenarios followed by a
// randomized phase, every cycle compared against a behavioural game model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [7:0]  scoreUpdate;
  logic        playerHit;
  logic        startGame;
  logic        gameEnded;
  logic        keyCoinN;
  logic [13:0] score;
  logic [13:0] hiScore;
  logic [2:0]  lives;
  logic [3:0]  credits;
  logic        gameLose;
  logic        invuln;

  score_keeper dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .scoreUpdate  (scoreUpdate),
    .playerHit    (playerHit),
    .startGame    (startGame),
    .gameEnded    (gameEnded),
    .keyCoinN     (keyCoinN),
    .score        (score),
    .hiScore      (hiScore),
    .lives        (lives),
    .credits      (credits),
    .gameLose     (gameLose),
    .invuln       (invuln)
  );

  always #5 clk = ~clk;

  int nCmp  = 0;
  int nFail = 0;

  // Game model: phase names, plain integers, and cycle stamps for the hit window.
  localparam int MIdle = 0, MPlay = 1, MDying = 2, MOver = 3;
  int mState, mScore, mHi, mLives, mCredits, mFrames, mCyc;
  int mLastSof, mLastHit;
  bit mLose, mInv, mBonus, mLastKey, mLastStart, mLastEnd;

  task automatic mReset();
    mState = MIdle; mScore = 0; mHi = 0; mLives = 0; mCredits = 0; mFrames = 0;
    mLose = 0; mInv = 0; mBonus = 0;
    mLastKey = 0;  // unknown key level at reset: a held key is not a press
    mLastStart = 0; mLastEnd = 0;
    mLastSof = -1; mLastHit = -1;
  endtask

  task automatic modelStep();
    bit coinEv, startEv, endEv, playing, startOk, hitOk, bonus;
    int newScore, newLives, newCredits;
    mCyc++;
    if (!resetN) begin
      mReset();
      return;
    end
    coinEv  = mLastKey && !keyCoinN;
    startEv = startGame && !mLastStart;
    endEv   = gameEnded && !mLastEnd;
    playing = (mState == MPlay) || (mState == MDying);
    startOk = startEv && (mCredits > 0) && !playing;
    hitOk   = (mState == MPlay) && playerHit && (mLastSof > mLastHit);
    newCredits = mCredits + int'(coinEv) - int'(startOk);
    mCredits = (newCredits > 9) ? 9 : newCredits;
    if (startOk) begin
      mState = MPlay; mScore = 0; mLives = 3; mLose = 0; mBonus = 0; mInv = 0;
    end else if (playing) begin
      newScore = mScore;
      if (scoreUpdate != 0) newScore = (mScore + scoreUpdate > 9999) ? 9999 : mScore + scoreUpdate;
      bonus = !mBonus && (newScore >= 1500);
      if (bonus) mBonus = 1;
      newLives = mLives + int'(bonus) - int'(hitOk);
      mLives = (newLives > 7) ? 7 : newLives;
      mScore = newScore;
      if (endEv || (hitOk && mLives == 0)) begin
        mState = MOver; mLose = 1; mInv = 0;
        if (mScore > mHi) mHi = mScore;
      end else if (hitOk) begin
        mState = MDying; mInv = 1; mFrames = 60;
      end else if (mState == MDying && startOfFrame) begin
        mFrames--;
        if (mFrames == 0) begin
          mState = MPlay; mInv = 0;
        end
      end
    end
    if (startOfFrame) mLastSof = mCyc;
    if (hitOk) mLastHit = mCyc;
    mLastKey = keyCoinN; mLastStart = startGame; mLastEnd = gameEnded;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    nCmp++;
    assert (got === $unsigned(exp)) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    chk("score", 32'(score), mScore);
    chk("hiScore", 32'(hiScore), mHi);
    chk("lives", 32'(lives), mLives);
    chk("credits", 32'(credits), mCredits);
    chk("gameLose", 32'(gameLose), int'(mLose));
    chk("invuln", 32'(invuln), int'(mInv));
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic pressCoin();
    keyCoinN = 0; cycle(); cycle();
    keyCoinN = 1; cycle(); cycle();
  endtask

  task automatic pressStart();
    startGame = 1; cycle(); cycle();
    startGame = 0; cycle();
  endtask

  task automatic frame();
    startOfFrame = 1; cycle();
    startOfFrame = 0; cycle();
  endtask

  task automatic kill(input int pts);
    scoreUpdate = 8'(pts); cycle();
    scoreUpdate = 0; cycle();
  endtask

  task automatic loseLife();
    frame();
    playerHit = 1; cycle();
    playerHit = 0;
    repeat (60) frame();
  endtask

  initial begin
    resetN = 0; startOfFrame = 0; scoreUpdate = 0; playerHit = 0;
    startGame = 0; gameEnded = 0; keyCoinN = 0;
    mCyc = 0;
    mReset();
    repeat (3) cycle();
    chk("rst score", 32'(score), 0);
    chk("rst lives", 32'(lives), 0);

    // Coin key held low through reset release is not a coin.
    resetN = 1;
    repeat (3) cycle();
    chk("heldCoin credits", 32'(credits), 0);
    keyCoinN = 1;
    repeat (2) cycle();

    // Start without credits is ignored.
    pressStart();
    chk("noCredit lives", 32'(lives), 0);
    chk("noCredit invuln", 32'(invuln), 0);

    // Three coins, then start.
    repeat (3) pressCoin();
    chk("3coins credits", 32'(credits), 3);
    pressStart();
    chk("start credits", 32'(credits), 2);
    chk("start lives", 32'(lives), 3);
    chk("start score", 32'(score), 0);

    // Bonus life exactly once.
    repeat (15) kill(100);
    chk("bonus score", 32'(score), 1500);
    chk("bonus lives", 32'(lives), 4);
    repeat (10) kill(100);
    chk("noRebonus lives", 32'(lives), 4);

    // Held hit within one frame costs one life; hits while dying are ignored.
    frame();
    playerHit = 1;
    repeat (200) cycle();
    chk("hit lives", 32'(lives), 3);
    chk("hit invuln", 32'(invuln), 1);
    repeat (30) frame();
    playerHit = 0;
    repeat (29) frame();
    chk("dying59 invuln", 32'(invuln), 1);
    chk("dying59 lives", 32'(lives), 3);
    frame();
    chk("respawn invuln", 32'(invuln), 0);

    // Score saturation.
    repeat (29) kill(250);
    kill(240);
    chk("score9990", 32'(score), 9990);
    kill(30);
    chk("score sat", 32'(score), 9999);
    kill(200);
    chk("score sat2", 32'(score), 9999);

    // Lose the remaining lives.
    loseLife();
    loseLife();
    chk("oneLife", 32'(lives), 1);
    frame();
    playerHit = 1; cycle();
    playerHit = 0; cycle();
    chk("over lives", 32'(lives), 0);
    chk("over gameLose", 32'(gameLose), 1);
    chk("over hiScore", 32'(hiScore), 9999);

    // Credit saturation.
    repeat (12) pressCoin();
    chk("coinSat", 32'(credits), 9);

    // Start from OVER drops gameLose one clock later.
    startGame = 1; cycle();
    chk("restart gameLose", 32'(gameLose), 0);
    chk("restart credits", 32'(credits), 8);
    startGame = 0; cycle();

    // Lower second game leaves hiScore alone; gameEnded forces OVER.
    kill(200); kill(200);
    gameEnded = 1; cycle();
    chk("ended gameLose", 32'(gameLose), 1);
    chk("ended hiScore", 32'(hiScore), 9999);
    gameEnded = 0; cycle();
    kill(100);
    chk("overIgnoresScore", 32'(score), 400);

    // Coin and start on one cycle: credits unchanged.
    keyCoinN = 0; startGame = 1; cycle();
    chk("coin+start credits", 32'(credits), 8);
    keyCoinN = 1; startGame = 0; cycle(); cycle();

    // Randomized play.
    for (int i = 0; i < 2500; i++) begin
      startOfFrame = (i % 4 == 0);
      scoreUpdate  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      playerHit    = !startOfFrame && ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) keyCoinN = ~keyCoinN;
      if ($urandom_range(0, 19) == 0) startGame = ~startGame;
      if ($urandom_range(0, 79) == 0) gameEnded = ~gameEnded;
      resetN = ($urandom_range(0, 999) != 0);
      cycle();
    end

    // Reset in the middle of a game.
    startOfFrame = 0; scoreUpdate = 0; playerHit = 0;
    startGame = 0; gameEnded = 0; keyCoinN = 1;
    resetN = 0; cycle();
    resetN = 1; cycle(); cycle();
    pressCoin(); pressCoin();
    pressStart();
    kill(50);
    chk("preReset score", 32'(score), 50);
    resetN = 0;
    #1;
    mReset();
    checkAll();
    chk("midRst credits", 32'(credits), 0);
    chk("midRst lives", 32'(lives), 0);
    cycle();
    resetN = 1; cycle();
    kill(100);
    chk("idleIgnoresScore", 32'(score), 0);
    frame();
    playerHit = 1; cycle();
    playerHit = 0; cycle();
    chk("idleIgnoresHit", 32'(invuln), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
